// File: rtl/moving_filter_pkg.sv
// rtl/moving_filter_pkg.sv - shared defaults, sample type, fill-state enum and clamp helper
package moving_filter_pkg;

   localparam int          DW_DEFAULT    = 16;
   localparam logic [17:0] GAIN_DEFAULT  = 18'd10486;
   localparam int          SHIFT_DEFAULT = 17;

   typedef logic signed [DW_DEFAULT-1:0] sample_t;

   // FILL: delay line not yet holding K real samples; RUN: steady state
   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } fill_state_e;

   // Clamp a wide signed value into the signed range of a dw-bit word
   function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] r;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
         r = hi;
      end else if (v < lo) begin
         r = lo;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/circ_delay_line.sv
// rtl/circ_delay_line.sv - circular delay line returning the oldest sample, read-before-write
module circ_delay_line
   import moving_filter_pkg::*;
#(
   parameter int DEPTH = 25,
   parameter int W     = DW_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   // Storage is left unreset so it can live in distributed RAM
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] wptr_d;

   // The slot about to be overwritten is the one written DEPTH samples ago
   assign dout = mem_q[wptr_q];

   // Advance the write pointer on each write, wrapping at the last slot
   always_comb begin
      wptr_d = wptr_q;
      if (we) begin
         wptr_d = (wptr_q == LAST) ? '0 : wptr_q + AW'(1);
      end
   end

   // Pointer register
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
      end
   end

   // Sample storage; dout is read combinationally before this write lands
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wptr_q] <= din;
      end
   end

endmodule

// File: rtl/moving_difference_filter.sv
// rtl/moving_difference_filter.sv - y = (x[n]-x[n-K])*GAIN >>> SHIFT; MOVING_DIFF_SATURATE_EN selects clamping over wrap
module moving_difference_filter
   import moving_filter_pkg::*;
#(
   parameter int          K     = 25,
   parameter logic [17:0] GAIN  = GAIN_DEFAULT,
   parameter int          SHIFT = SHIFT_DEFAULT,
   parameter int          DW    = DW_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic signed [DW-1:0] x,
   output logic signed [DW-1:0] y,
   output logic                 valid,
   output logic                 ovf
);

   localparam int            PW       = DW + 19;
   localparam int            CW       = $clog2(K + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

   // Stage 0: input register
   logic                 en0_q, en0_d;
   logic signed [DW-1:0] x0_q, x0_d;
   // Stage 1: difference
   logic                 tok1_q, tok1_d;
   logic                 v1_q, v1_d;
   logic signed [DW:0]   d1_q, d1_d;
   // Stage 2: product
   logic                 tok2_q, tok2_d;
   logic                 v2_q, v2_d;
   logic signed [PW-1:0] p2_q, p2_d;
   // Stage 3: outputs
   logic signed [DW-1:0] y_q, y_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;
   // Fill tracking
   fill_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [DW-1:0]        oldest;
   logic signed [DW-1:0] old;
   logic signed [PW-1:0] q;
   logic                 q_out_of_range;
   logic signed [DW-1:0] q_fit;

   circ_delay_line #(
      .DEPTH(K),
      .W    (DW)
   ) u_delay (
      .clk  (clk),
      .reset(reset),
      .we   (en0_q),
      .din  (x0_q),
      .dout (oldest)
   );

   // Buffer contents are meaningless until K samples have been written
   assign old = (state_q == RUN) ? $signed(oldest) : '0;

   // Fill FSM: count accepted samples, switch to RUN on the K-th one
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (en0_q && (state_q == FILL)) begin
         if (cnt_q == CNT_LAST) begin
            state_d = RUN;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Pipeline next-state: stages always advance, data only moves on tokens
   always_comb begin
      en0_d  = enable;
      x0_d   = x;
      tok1_d = en0_q;
      d1_d   = d1_q;
      v1_d   = v1_q;
      if (en0_q) begin
         d1_d = {x0_q[DW-1], x0_q} - {old[DW-1], old};
         v1_d = (state_q == RUN);
      end
      tok2_d = tok1_q;
      v2_d   = v1_q;
      p2_d   = PW'(d1_q) * PW'($signed({1'b0, GAIN}));
   end

   // Floor shift, then detect whether the result fits in DW bits
   assign q              = p2_q >>> SHIFT;
   assign q_out_of_range = !(&q[PW-1:DW-1]) && (|q[PW-1:DW-1]);

`ifdef MOVING_DIFF_SATURATE_EN
   logic signed [63:0] q_sat;
   assign q_sat = sat_dw(64'(q), DW);
   assign q_fit = q_sat[DW-1:0];
`else
   assign q_fit = q[DW-1:0];
`endif

   // Output stage: update y/valid only when a token arrives; ovf is sticky
   always_comb begin
      y_d     = y_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (tok2_q) begin
         y_d     = q_fit;
         valid_d = v2_q;
         if (q_out_of_range) begin
            ovf_d = 1'b1;
         end
      end
   end

   // State registers; reset discards all in-flight tokens and restarts the fill
   always_ff @(posedge clk) begin
      if (reset) begin
         en0_q   <= 1'b0;
         x0_q    <= '0;
         tok1_q  <= 1'b0;
         v1_q    <= 1'b0;
         d1_q    <= '0;
         tok2_q  <= 1'b0;
         v2_q    <= 1'b0;
         p2_q    <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         state_q <= FILL;
         cnt_q   <= '0;
      end else begin
         en0_q   <= en0_d;
         x0_q    <= x0_d;
         tok1_q  <= tok1_d;
         v1_q    <= v1_d;
         d1_q    <= d1_d;
         tok2_q  <= tok2_d;
         v2_q    <= v2_d;
         p2_q    <= p2_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign y     = y_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_moving_difference_filter.sv
// tb/tb_moving_difference_filter.sv - directed and random checks of four filter configurations against a reference model
module tb_moving_difference_filter;
   import moving_filter_pkg::*;

   localparam int NDUT = 4;

`ifdef MOVING_DIFF_SATURATE_EN
   localparam int T4_Y = 32767;
`else
   localparam int T4_Y = 28928;
`endif

   logic    clk = 1'b0;
   logic    reset;
   logic    enable;
   sample_t x;
   sample_t dy     [NDUT];
   logic    dvalid [NDUT];
   logic    dovf   [NDUT];

   always #5 clk = ~clk;

   moving_difference_filter #(.K(4), .GAIN(18'd131072), .SHIFT(17), .DW(16)) u_k4 (
      .clk(clk), .reset(reset), .enable(enable), .x(x),
      .y(dy[0]), .valid(dvalid[0]), .ovf(dovf[0]));

   moving_difference_filter #(.K(25), .GAIN(18'd10486), .SHIFT(17), .DW(16)) u_def (
      .clk(clk), .reset(reset), .enable(enable), .x(x),
      .y(dy[1]), .valid(dvalid[1]), .ovf(dovf[1]));

   moving_difference_filter #(.K(4), .GAIN(18'd131072), .SHIFT(15), .DW(16)) u_g4 (
      .clk(clk), .reset(reset), .enable(enable), .x(x),
      .y(dy[2]), .valid(dvalid[2]), .ovf(dovf[2]));

   moving_difference_filter #(.K(1), .GAIN(18'd131072), .SHIFT(17), .DW(16)) u_k1 (
      .clk(clk), .reset(reset), .enable(enable), .x(x),
      .y(dy[3]), .valid(dvalid[3]), .ovf(dovf[3]));

   typedef struct {
      int                 due;
      int                 idx;
      logic signed [15:0] y;
      logic               valid;
      logic               ovf;
   } result_t;

   result_t            pending[$];
   int                 hist[$];
   logic signed [15:0] exp_y   [NDUT];
   logic               exp_v   [NDUT];
   logic               exp_ovf [NDUT];
   int                 cyc    = 0;
   int                 checks = 0;
   int                 errors = 0;

   function automatic int cfg_k(input int i);
      case (i)
         0:       return 4;
         1:       return 25;
         2:       return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int cfg_gain(input int i);
      return (i == 1) ? 10486 : 131072;
   endfunction

   function automatic int cfg_shift(input int i);
      return (i == 2) ? 15 : 17;
   endfunction

   // Reference: n-th accepted sample since reset is differenced against sample n-K (0 while n<K)
   task automatic model_result(input int i, input int xv, output logic signed [15:0] yv,
                               output logic vv, output logic ov);
      int     n;
      longint old;
      longint q;
      n   = hist.size();
      old = (n >= cfg_k(i)) ? longint'(hist[n - cfg_k(i)]) : 64'sd0;
      vv  = (n >= cfg_k(i));
      q   = ((longint'(xv) - old) * longint'(cfg_gain(i))) >>> cfg_shift(i);
      ov  = (q > 32767) || (q < -32768);
`ifdef MOVING_DIFF_SATURATE_EN
      if (q > 32767) yv = 16'h7fff;
      else if (q < -32768) yv = 16'h8000;
      else yv = 16'(q);
`else
      yv = 16'(q);
`endif
   endtask

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s dut%0d cyc%0d: observed %0d expected %0d", tag, i, cyc,
                $signed(obs), $signed(expv));
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NDUT; i++) begin
         chk("y", i, 32'(dy[i]), 32'(exp_y[i]));
         chk("valid", i, 32'(dvalid[i]), 32'(exp_v[i]));
         chk("ovf", i, 32'(dovf[i]), 32'(exp_ovf[i]));
      end
   endtask

   // Drive one cycle of inputs, advance the model, compare every DUT after the edge
   task automatic step(input logic rst, input logic en, input int xv);
      result_t            r;
      logic signed [15:0] yv;
      logic               vv;
      logic               ov;
      reset  = rst;
      enable = en;
      x      = 16'(xv);
      if (rst) begin
         pending.delete();
         hist.delete();
      end else if (en) begin
         for (int i = 0; i < NDUT; i++) begin
            model_result(i, xv, yv, vv, ov);
            r.due   = cyc + 4;
            r.idx   = i;
            r.y     = yv;
            r.valid = vv;
            r.ovf   = ov;
            pending.push_back(r);
         end
         hist.push_back(xv);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         for (int i = 0; i < NDUT; i++) begin
            exp_y[i]   = '0;
            exp_v[i]   = 1'b0;
            exp_ovf[i] = 1'b0;
         end
      end
      while (pending.size() > 0 && pending[0].due <= cyc) begin
         r = pending.pop_front();
         exp_y[r.idx] = r.y;
         exp_v[r.idx] = r.valid;
         if (r.ovf) exp_ovf[r.idx] = 1'b1;
      end
      check_all();
   endtask

   int cnt80;

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      x      = '0;

      // Reset state
      repeat (3) step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 0);

      // Test 1: constant 100, K=4 unity gain; first update lands 4 cycles after first enable
      for (int j = 1; j <= 8; j++) begin
         step(1'b0, 1'b1, 100);
         if (j == 3) chk("t1_before_first", 0, 32'(dy[0]), 32'd0);
         if (j == 4) begin
            chk("t1_first_y", 0, 32'(dy[0]), 32'd100);
            chk("t1_first_valid", 0, 32'(dvalid[0]), 32'd0);
         end
         if (j == 8) begin
            chk("t1_run_y", 0, 32'(dy[0]), 32'd0);
            chk("t1_run_valid", 0, 32'(dvalid[0]), 32'd1);
         end
      end

      // Test 2: defaults, prime with 0 then step to 1000; expect exactly 25 outputs of 80
      step(1'b1, 1'b0, 0);
      repeat (30) step(1'b0, 1'b1, 0);
      cnt80 = 0;
      for (int j = 0; j < 35; j++) begin
         step(1'b0, 1'b1, 1000);
         if (dy[1] == 16'sd80 && dvalid[1]) cnt80++;
      end
      chk("t2_count80", 1, 32'(cnt80), 32'd25);
      chk("t2_tail_y", 1, 32'(dy[1]), 32'd0);
      chk("t2_tail_valid", 1, 32'(dvalid[1]), 32'd1);

      // Test 3: ramp, continuous then with enable toggled; bubbles carry junk x
      step(1'b1, 1'b0, 0);
      for (int j = 0; j < 12; j++) step(1'b0, 1'b1, 10 * j);
      chk("t3_ramp_y", 0, 32'(dy[0]), 32'd40);
      step(1'b1, 1'b0, 0);
      for (int j = 0; j < 12; j++) begin
         step(1'b0, 1'b1, 10 * j);
         step(1'b0, 1'b0, int'($urandom_range(0, 65535)) - 32768);
      end
      repeat (3) step(1'b0, 1'b0, 0);
      chk("t3_gapped_y", 0, 32'(dy[0]), 32'd40);

      // Test 4: gain 4 overflow on a 40000 step
      step(1'b1, 1'b0, 0);
      repeat (4) step(1'b0, 1'b1, -20000);
      repeat (4) step(1'b0, 1'b1, 20000);
      repeat (4) step(1'b0, 1'b0, 0);
      chk("t4_y", 2, 32'(dy[2]), 32'(T4_Y));
      chk("t4_ovf", 2, 32'(dovf[2]), 32'd1);

      // Test 5: reset with tokens in flight, then a full refill is needed
      step(1'b1, 1'b0, 0);
      for (int j = 0; j < 10; j++) step(1'b0, 1'b1, 300 * j - 1000);
      step(1'b1, 1'b1, 555);
      chk("t5_rst_y", 0, 32'(dy[0]), 32'd0);
      chk("t5_rst_valid", 0, 32'(dvalid[0]), 32'd0);
      chk("t5_rst_ovf", 0, 32'(dovf[0]), 32'd0);
      for (int j = 0; j < 5; j++) begin
         step(1'b0, 1'b0, 0);
         chk("t5_no_stale_y", 0, 32'(dy[0]), 32'd0);
      end
      repeat (4) step(1'b0, 1'b1, 77);
      repeat (4) step(1'b0, 1'b0, 0);
      chk("t5_fill_valid", 0, 32'(dvalid[0]), 32'd0);
      step(1'b0, 1'b1, 80);
      repeat (4) step(1'b0, 1'b0, 0);
      chk("t5_refill_valid", 0, 32'(dvalid[0]), 32'd1);
      chk("t5_refill_y", 0, 32'(dy[0]), 32'd3);

      // Test 6: K=1, x = 5, 7, 4
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 5);
      step(1'b0, 1'b1, 7);
      step(1'b0, 1'b1, 4);
      step(1'b0, 1'b0, 0);
      chk("t6_y0", 3, 32'(dy[3]), 32'd5);
      chk("t6_v0", 3, 32'(dvalid[3]), 32'd0);
      step(1'b0, 1'b0, 0);
      chk("t6_y1", 3, 32'(dy[3]), 32'd2);
      chk("t6_v1", 3, 32'(dvalid[3]), 32'd1);
      step(1'b0, 1'b0, 0);
      chk("t6_y2", 3, 32'(dy[3]), 32'hffff_fffd);
      chk("t6_v2", 3, 32'(dvalid[3]), 32'd1);

      // Random traffic: gaps, occasional resets, small and full-range samples
      for (int j = 0; j < 1500; j++) begin
         logic rb;
         logic eb;
         int   xv;
         rb = ($urandom_range(0, 99) == 0);
         eb = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) == 0) xv = int'($urandom_range(0, 65535)) - 32768;
         else xv = int'($urandom_range(0, 4000)) - 2000;
         step(rb, eb, xv);
      end
      repeat (6) step(1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/moving_difference_filter.md
Name: moving_difference_filter

Overview:
K-sample moving-difference filter with fixed-point gain: y[n] = sat((x[n] - x[n-K]) * GAIN >>> SHIFT). It is the complementary stage to the moving-integrator pedestal-recovery filter. It sits in the per-channel self-trigger chain, after pedestal subtraction and ahead of the trigger comparator. It flags outputs as valid only once the delay line holds K real samples.

Parameters:
K, 25, delay depth in samples; legal range 1..64
GAIN, 18'd10486, unsigned 18-bit gain multiplier
SHIFT, 17, arithmetic right shift applied to the product; legal range 0..34
DW, 16, sample width (signed)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
enable  in  1  sample strobe; x is accepted on cycles where enable=1
x  in  DW  signed input sample
y  out  DW  signed filtered output; holds between updates
valid  out  1  high when y reflects a full K-sample difference; updates together with y
ovf  out  1  sticky: a result exceeded the DW range since reset

Behaviour:
- Reset values: y=0, valid=0, ovf=0. All pipeline tokens cleared, write pointer=0, fill count=0, state=FILL.
- Stage 0 (input register): en_r<=enable, x_r<=x every cycle.
- Stage 1 (delay line), when en_r=1:
  - read buffer[wptr] (oldest sample), write x_r to buffer[wptr].
  - Read-before-write at the same address.
  - wptr wraps from K-1 to 0.
  - d_r <= x_r - old, computed at (DW+1) bits signed.
  - tok1 <= en_r.
- Fill state machine (advances on each accepted sample):
  - FILL: old is forced to 0, because buffer contents are undefined after reset. fill count increments. On the K-th accepted sample, go to RUN. That K-th sample itself still uses old=0.
  - RUN: old comes from the buffer. The state stays RUN until reset.
  - The sample's state is carried down the pipeline as vtag.
- Stage 2: p_r <= d_r * GAIN, signed (DW+1) x unsigned 18, giving (DW+19) bits. Tokens and vtag shift along.
- Stage 3: q = p_r >>> SHIFT (floor). The result is then reduced to DW bits (see Optional Feature). On a token: y<=result, valid<=vtag.
  - No token: y and valid hold.
- Latency: x presented with enable at cycle n → y/valid update at the n+4 clock edge. Throughput is 1 sample/cycle.
- Enable gaps:
  - pipeline stages always advance; gaps become bubbles.
  - the buffer and pointer do not move on bubble cycles.
  - output sequence is identical to gap-free input, only spaced.
- ovf: set when q lies outside [-2^(DW-1), 2^(DW-1)-1]. Cleared only by reset.
- Reset mid-operation:
  - in-flight tokens are discarded; no y update follows reset.
  - refill of K samples is required before valid returns.
- K=1: the difference is against the immediately preceding accepted sample. The first output after reset has valid=0.

Optional Feature:
Macro MOVING_DIFF_SATURATE_EN.
- Defined: results out of range clamp to 2^(DW-1)-1 or -2^(DW-1).
- Undefined: y takes q[DW-1:0], i.e. two's-complement wrap.
- ovf behaves the same in both builds.

Decomposition:
- Package moving_filter_pkg holds:
  - DW_DEFAULT=16
  - GAIN_DEFAULT=18'd10486
  - SHIFT_DEFAULT=17
  - a sample_t typedef (signed DW)
  - a sat_dw function (signed wide → DW, clamping)
  - the fill state enum {FILL, RUN}
- Sub-module circ_delay_line (params DEPTH, W):
  - inputs: clk, reset, we, din
  - output: dout, the oldest sample, read-before-write
  - owns wptr and its wrap logic
  - maps to distributed RAM.

Test Plan:
- Test 1. K=4, GAIN=131072, SHIFT=17 (unity gain); x=100 enabled continuously → first 4 outputs y=100 with valid=0, then y=0 with valid=1. First update lands 4 cycles after the first enable.
- Test 2. Defaults; x steps from 0 to 1000 after priming → y=80 for exactly 25 outputs, then y=0; valid stays 1 throughout.
- Test 3. K=4, unity gain; ramp x=0,10,20,… → after fill, y=40 constant. Same sequence with enable toggled every other cycle → identical y values, spaced 2 cycles apart.
- Test 4. K=4, GAIN=131072, SHIFT=15 (gain 4); x=-20000 for 4 samples, then 20000 → difference 40000 gives q=160000.
  - With SATURATE_EN: y=32767, ovf=1.
  - Without: y=28928, ovf=1.
- Test 5. Assert reset while 3 tokens are in flight and after 10 samples → y=0, valid=0, ovf=0 next cycle, with no later y update from the discarded tokens. Then 4 samples are needed before valid=1 again (K=4).
- Test 6. K=1, unity gain; x=5,7,4 → y=5 (valid=0), 2 (valid=1), -3 (valid=1).
